sdhc_ring_sched: RTL and testbench

Command-ring scheduler for the SD host controller.
- Fetches 8-byte descriptors from the 4KB command ring over the shared DMA port and checks them against the consumer phase.
- Hands each valid descriptor to the SD command/data engine through a valid/ready handshake.
- Writes back the completion word and advances the ring index, toggling phase on wrap.
- Sits between the MMIO register file, the DMA bus and the SD command engine.

---
 rtl/sdhc_pkg.sv | 28 ++
 rtl/sdhc_ring_sched.sv | 216 +++++++++++++++++++++
 tb/tb_sdhc_ring_sched.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdhc_pkg.sv
// Shared definitions for the SD host command-ring scheduler: descriptor layout,
// ring geometry helper and scheduler state encoding.
package sdhc_pkg;

   localparam int DESC_PHASE    = 0;
   localparam int DESC_RW       = 1;
   localparam int DESC_IRQ      = 2;
   localparam int DESC_ADDR_LSB = 4;
   localparam int DESC_ADDR_MSB = 25;
   localparam int LOG2CMDBYTES  = 3;

   // Index width of a ring that fills one page with 8-byte descriptors.
   function automatic int ringindexw(input int log2pagesz);
      return log2pagesz - LOG2CMDBYTES;
   endfunction

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH0    = 3'd1,
      FETCH1    = 3'd2,
      ISSUE     = 3'd3,
      WAIT      = 3'd4,
      WRITEBACK = 3'd5,
      ADVANCE   = 3'd6,
      STALLED   = 3'd7
   } sched_state_t;

endpackage

// File: rtl/sdhc_ring_sched.sv
// Command-ring scheduler: fetches descriptors over the DMA port, hands them to the
// SD command engine, writes back the completion word and advances the ring.
module sdhc_ring_sched
   import sdhc_pkg::*;
#(
   parameter int  ADDRW      = 26,
   parameter int  LOG2PAGESZ = 12,
   parameter int  TIMEOUTW   = 24,
   localparam int RINGINDEXW = ringindexw(LOG2PAGESZ),
   localparam int PFNW       = ADDRW - LOG2PAGESZ
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  doorbell,
   input  logic                  ring_load,
   input  logic [PFNW-1:0]       ring_pfn,
   input  logic                  phase_in,
   output logic                  consumer_phase,
   output logic [RINGINDEXW-1:0] ring_index,
   output logic                  dma_req,
   output logic                  dma_we,
   output logic [ADDRW-1:0]      dma_addr,
   output logic [31:0]           dma_wr_data,
   input  logic                  dma_ack,
   input  logic [31:0]           dma_rd_data,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [ADDRW-1:0]      cmd_buf_addr,
   output logic                  cmd_rw,
   output logic [31:0]           cmd_lba,
   input  logic                  cmd_done,
   input  logic                  cmd_ok,
   output logic                  cmd_abort,
   output logic                  completion_irq,
   output logic                  timeout_err,
   output logic                  busy
);

   sched_state_t          r_state;
   logic [PFNW-1:0]       r_ring_pfn;
   logic [RINGINDEXW-1:0] r_ring_index;
   logic                  r_consumer_phase;
   logic                  r_load_seen;
   logic                  r_irq;
   logic                  r_phase;
   logic                  r_ok;
   logic [ADDRW-1:0]      r_desc_addr;
   logic                  r_dma_req;
   logic                  r_dma_we;
   logic [ADDRW-1:0]      r_dma_addr;
   logic [31:0]           r_dma_wr_data;
   logic                  r_cmd_valid;
   logic [ADDRW-1:0]      r_cmd_buf_addr;
   logic                  r_cmd_rw;
   logic [31:0]           r_cmd_lba;
   logic                  r_cmd_abort;
   logic                  r_completion_irq;
   logic                  r_timeout_err;
   logic [TIMEOUTW-1:0]   r_timeout_cnt;

   logic [ADDRW-1:0]      w_desc_addr;
   logic [ADDRW-1:0]      w_buf_addr;
   logic [TIMEOUTW-1:0]   w_timeout_next;
   logic                  w_in_flight;
   logic                  w_unused;

   assign w_desc_addr    = {r_ring_pfn, r_ring_index, {LOG2CMDBYTES{1'b0}}};
   assign w_buf_addr     = ADDRW'({dma_rd_data[DESC_ADDR_MSB:DESC_ADDR_LSB], {DESC_ADDR_LSB{1'b0}}});
   assign w_timeout_next = r_timeout_cnt + TIMEOUTW'(1);
   // ADVANCE is excluded: a load landing there already zeroes the index itself.
   assign w_in_flight    = (r_state == FETCH0) || (r_state == FETCH1) || (r_state == ISSUE) ||
                           (r_state == WAIT)   || (r_state == WRITEBACK);
   assign w_unused       = &{1'b0, dma_rd_data[31:DESC_ADDR_MSB+1], dma_rd_data[3]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= IDLE;
         r_ring_pfn       <= '0;
         r_ring_index     <= '0;
         r_consumer_phase <= 1'b0;
         r_load_seen      <= 1'b0;
         r_irq            <= 1'b0;
         r_phase          <= 1'b0;
         r_ok             <= 1'b0;
         r_desc_addr      <= '0;
         r_dma_req        <= 1'b0;
         r_dma_we         <= 1'b0;
         r_dma_addr       <= '0;
         r_dma_wr_data    <= '0;
         r_cmd_valid      <= 1'b0;
         r_cmd_buf_addr   <= '0;
         r_cmd_rw         <= 1'b0;
         r_cmd_lba        <= '0;
         r_cmd_abort      <= 1'b0;
         r_completion_irq <= 1'b0;
         r_timeout_err    <= 1'b0;
         r_timeout_cnt    <= '0;
      end else begin
         r_cmd_abort      <= 1'b0;
         r_completion_irq <= 1'b0;
         case (r_state)
            IDLE: begin
               if (enable && doorbell) begin
                  r_load_seen <= 1'b0;
                  r_state     <= FETCH0;
               end
            end
            STALLED: begin
               if (doorbell) begin
                  r_load_seen <= 1'b0;
                  r_state     <= enable ? FETCH0 : IDLE;
               end
            end
            FETCH0: begin
               if (!r_dma_req) begin
                  r_desc_addr <= w_desc_addr;
                  r_dma_req   <= 1'b1;
                  r_dma_we    <= 1'b0;
                  r_dma_addr  <= w_desc_addr;
               end else if (dma_ack) begin
                  r_dma_req <= 1'b0;
                  if (dma_rd_data[DESC_PHASE] != r_consumer_phase) begin
                     r_state <= STALLED;
                  end else begin
                     r_irq          <= dma_rd_data[DESC_IRQ];
                     r_phase        <= dma_rd_data[DESC_PHASE];
                     r_cmd_rw       <= dma_rd_data[DESC_RW];
                     r_cmd_buf_addr <= w_buf_addr;
                     r_state        <= FETCH1;
                  end
               end
            end
            FETCH1: begin
               if (!r_dma_req) begin
                  r_dma_req  <= 1'b1;
                  r_dma_we   <= 1'b0;
                  r_dma_addr <= r_desc_addr + ADDRW'(4);
               end else if (dma_ack) begin
                  r_dma_req   <= 1'b0;
                  r_cmd_lba   <= dma_rd_data;
                  r_cmd_valid <= 1'b1;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (cmd_ready) begin
                  r_cmd_valid   <= 1'b0;
                  r_timeout_cnt <= '0;
                  r_state       <= WAIT;
               end
            end
            WAIT: begin
               r_timeout_cnt <= w_timeout_next;
               if (cmd_done) begin
                  r_ok    <= cmd_ok;
                  r_state <= WRITEBACK;
               end else if (&w_timeout_next) begin
                  r_ok          <= 1'b0;
                  r_cmd_abort   <= 1'b1;
                  r_timeout_err <= 1'b1;
                  r_state       <= WRITEBACK;
               end
            end
            WRITEBACK: begin
               if (!r_dma_req) begin
                  r_dma_req     <= 1'b1;
                  r_dma_we      <= 1'b1;
                  r_dma_addr    <= r_desc_addr;
                  r_dma_wr_data <= {29'b0, r_irq, r_ok, r_phase};
               end else if (dma_ack) begin
                  r_dma_req        <= 1'b0;
                  r_dma_we         <= 1'b0;
                  r_completion_irq <= r_irq;
                  r_state          <= ADVANCE;
               end
            end
            ADVANCE: begin
               if (!r_load_seen) begin
                  r_ring_index <= r_ring_index + RINGINDEXW'(1);
                  if (&r_ring_index)
                     r_consumer_phase <= ~r_consumer_phase;
               end
               r_load_seen <= 1'b0;
               r_state     <= enable ? FETCH0 : IDLE;
            end
            default: r_state <= IDLE;
         endcase

         // A ring reload overrides any index/phase update made above this cycle.
         if (ring_load) begin
            r_ring_pfn       <= ring_pfn;
            r_ring_index     <= '0;
            r_consumer_phase <= phase_in;
            r_timeout_err    <= 1'b0;
            r_load_seen      <= w_in_flight;
         end
      end
   end

   assign consumer_phase = r_consumer_phase;
   assign ring_index     = r_ring_index;
   assign dma_req        = r_dma_req;
   assign dma_we         = r_dma_we;
   assign dma_addr       = r_dma_addr;
   assign dma_wr_data    = r_dma_wr_data;
   assign cmd_valid      = r_cmd_valid;
   assign cmd_buf_addr   = r_cmd_buf_addr;
   assign cmd_rw         = r_cmd_rw;
   assign cmd_lba        = r_cmd_lba;
   assign cmd_abort      = r_cmd_abort;
   assign completion_irq = r_completion_irq;
   assign timeout_err    = r_timeout_err;
   assign busy           = (r_state != IDLE) && (r_state != STALLED);

endmodule

// File: tb/tb_sdhc_ring_sched.sv
// Directed bench for sdhc_ring_sched: a DMA memory responder and an SD engine model
// drive the scheduler through fetch, stall, wrap, timeout, reload and reset cases.
module tb_sdhc_ring_sched;

   logic        clk = 1'b0;
   logic        rst_n, enable, doorbell, ring_load, phase_in;
   logic [13:0] ring_pfn;
   logic        consumer_phase;
   logic [8:0]  ring_index;
   logic        dma_req, dma_we, dma_ack;
   logic [25:0] dma_addr;
   logic [31:0] dma_wr_data, dma_rd_data;
   logic        cmd_valid, cmd_ready, cmd_rw, cmd_done, cmd_ok, cmd_abort;
   logic [25:0] cmd_buf_addr;
   logic [31:0] cmd_lba;
   logic        completion_irq, timeout_err, busy;

   sdhc_ring_sched #(.ADDRW(26), .LOG2PAGESZ(12), .TIMEOUTW(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .doorbell(doorbell),
      .ring_load(ring_load), .ring_pfn(ring_pfn), .phase_in(phase_in),
      .consumer_phase(consumer_phase), .ring_index(ring_index),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wr_data(dma_wr_data),
      .dma_ack(dma_ack), .dma_rd_data(dma_rd_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_buf_addr(cmd_buf_addr),
      .cmd_rw(cmd_rw), .cmd_lba(cmd_lba), .cmd_done(cmd_done), .cmd_ok(cmd_ok),
      .cmd_abort(cmd_abort), .completion_irq(completion_irq),
      .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic we; logic [25:0] addr; logic [31:0] data; } dma_t;
   typedef struct { logic [25:0] baddr; logic rw; logic [31:0] lba; } cmd_t;

   logic [31:0] mem [int];
   dma_t        dlog[$];
   cmd_t        clog[$];
   int          dptr = 0, cptr = 0;
   int          n_cmp = 0, n_err = 0;
   int          cyc = 0;
   int          ack_delay = 0, done_delay = 2;
   logic        done_en = 1'b1, ok_val = 1'b1;
   int          pend = -1, irq_cnt = 0, abort_cnt = 0, hs_cyc = 0, abort_cyc = 0;
   logic        seen = 1'b0;
   int          waitc = 0;
   logic        cap_we;
   logic [25:0] cap_addr;
   logic [31:0] cap_data;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // DMA responder: optional ack latency, checks request stability while waiting.
   always @(negedge clk) begin
      if (!rst_n) begin
         dma_ack = 1'b0; seen = 1'b0; waitc = 0;
      end else if (dma_ack) begin
         dma_ack = 1'b0;
      end else if (dma_req) begin
         if (!seen) begin
            seen = 1'b1; waitc = 0;
            cap_we = dma_we; cap_addr = dma_addr; cap_data = dma_wr_data;
         end
         if (waitc >= ack_delay) begin
            if (ack_delay > 0)
               chk("dma_stable", {5'b0, dma_we, dma_addr, dma_wr_data}, {5'b0, cap_we, cap_addr, cap_data});
            if (dma_we) begin
               mem[int'(dma_addr)] = dma_wr_data;
               dlog.push_back('{1'b1, dma_addr, dma_wr_data});
            end else begin
               dma_rd_data = mem.exists(int'(dma_addr)) ? mem[int'(dma_addr)] : 32'h0;
               dlog.push_back('{1'b0, dma_addr, dma_rd_data});
            end
            $display("dma %s addr=%06h data=%08h", dma_we ? "wr" : "rd", dma_addr,
                     dma_we ? dma_wr_data : dma_rd_data);
            dma_ack = 1'b1; seen = 1'b0;
         end else begin
            waitc++;
         end
      end else begin
         seen = 1'b0;
      end
   end

   // SD engine model: accepts every command, completes after done_delay if enabled.
   always @(negedge clk) begin
      if (!rst_n) begin
         cmd_done = 1'b0; pend = -1;
      end else begin
         if (cmd_done) cmd_done = 1'b0;
         if (completion_irq) irq_cnt++;
         if (cmd_abort) begin
            abort_cyc = cyc; abort_cnt++; pend = -1;
         end
         if (pend > 0) pend--;
         else if (pend == 0) begin
            cmd_done = 1'b1; cmd_ok = ok_val; pend = -1;
         end
         if (cmd_valid && cmd_ready) begin
            clog.push_back('{cmd_buf_addr, cmd_rw, cmd_lba});
            hs_cyc = cyc + 1;
            pend = done_en ? done_delay : -1;
            $display("cmd buf=%06h rw=%0d lba=%08h", cmd_buf_addr, cmd_rw, cmd_lba);
         end
      end
   end

   task automatic pulse_ring_load(input logic [13:0] pfn, input logic ph);
      ring_pfn = pfn; phase_in = ph; ring_load = 1'b1;
      @(negedge clk);
      ring_load = 1'b0;
   endtask

   task automatic pulse_doorbell();
      doorbell = 1'b1;
      @(negedge clk);
      doorbell = 1'b0;
   endtask

   task automatic expect_dma(input string tag, input logic we, input logic [25:0] addr, input logic [31:0] data);
      for (int k = 0; k < 300 && dlog.size() <= dptr; k++) @(negedge clk);
      if (dlog.size() <= dptr) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         chk({tag, "_we"}, dlog[dptr].we, we);
         chk({tag, "_addr"}, dlog[dptr].addr, addr);
         if (we) chk({tag, "_data"}, dlog[dptr].data, data);
         dptr++;
      end
   endtask

   task automatic expect_cmd(input string tag, input logic [25:0] baddr, input logic rw, input logic [31:0] lba);
      for (int k = 0; k < 300 && clog.size() <= cptr; k++) @(negedge clk);
      if (clog.size() <= cptr) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         chk({tag, "_buf"}, clog[cptr].baddr, baddr);
         chk({tag, "_rw"}, clog[cptr].rw, rw);
         chk({tag, "_lba"}, clog[cptr].lba, lba);
         cptr++;
      end
   endtask

   task automatic wait_index(input string tag, input logic [8:0] v);
      for (int k = 0; k < 300 && ring_index != v; k++) @(negedge clk);
      chk(tag, ring_index, v);
   endtask

   initial begin
      int irq0, abort0, cbase;
      rst_n = 1'b0; enable = 1'b0; doorbell = 1'b0; ring_load = 1'b0;
      ring_pfn = '0; phase_in = 1'b0; cmd_ready = 1'b1;
      dma_ack = 1'b0; dma_rd_data = '0; cmd_done = 1'b0; cmd_ok = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_dma_req", dma_req, 0);
      chk("rst_dma_addr", dma_addr, 0);
      chk("rst_dma_wr_data", dma_wr_data, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_cmd_lba", cmd_lba, 0);
      chk("rst_index", ring_index, 0);
      chk("rst_phase", consumer_phase, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: basic entry
      mem[32'h40000] = 32'h00012347; mem[32'h40004] = 32'h00000800;
      mem[32'h40008] = 32'h00000AB0;
      enable = 1'b1;
      pulse_ring_load(14'h0040, 1'b1);
      chk("t1_phase_load", consumer_phase, 1);
      irq0 = irq_cnt;
      pulse_doorbell();
      expect_dma("t1_rd0", 1'b0, 26'h040000, 32'h0);
      expect_dma("t1_rd1", 1'b0, 26'h040004, 32'h0);
      expect_cmd("t1_cmd", 26'h012340, 1'b1, 32'h800);
      expect_dma("t1_wb", 1'b1, 26'h040000, 32'h7);
      wait_index("t1_index", 9'd1);
      chk("t1_irq", irq_cnt - irq0, 1);

      // 2: phase mismatch stalls, then resumes after fix-up
      expect_dma("t2_rd_stall", 1'b0, 26'h040008, 32'h0);
      repeat (3) @(negedge clk);
      chk("t2_busy", busy, 0);
      chk("t2_no_cmd", clog.size(), 1);
      mem[32'h40008] = 32'h00000AB1; mem[32'h4000C] = 32'h00001234;
      pulse_doorbell();
      expect_dma("t2_rd0", 1'b0, 26'h040008, 32'h0);
      expect_dma("t2_rd1", 1'b0, 26'h04000C, 32'h0);
      expect_cmd("t2_cmd", 26'h000AB0, 1'b0, 32'h1234);
      expect_dma("t2_wb", 1'b1, 26'h040008, 32'h3);
      wait_index("t2_index", 9'd2);
      expect_dma("t2_rd_next", 1'b0, 26'h040010, 32'h0);

      // 3: full ring wrap
      done_delay = 1;
      for (int i = 0; i < 512; i++) begin
         mem[32'h60000 + 8 * i] = (i << 4) | 1;
         mem[32'h60004 + 8 * i] = i;
      end
      repeat (2) @(negedge clk);
      pulse_ring_load(14'h0060, 1'b1);
      cbase = clog.size();
      pulse_doorbell();
      for (int k = 0; k < 20000 && clog.size() < cbase + 512; k++) @(negedge clk);
      for (int k = 0; k < 100 && busy; k++) @(negedge clk);
      chk("t3_count", clog.size() - cbase, 512);
      chk("t3_last_lba", clog[clog.size() - 1].lba, 511);
      chk("t3_index", ring_index, 0);
      chk("t3_phase", consumer_phase, 0);
      chk("t3_busy", busy, 0);
      chk("t3_last_wb", mem[32'h60FF8], 32'h3);
      chk("t3_stall_addr", dlog[dlog.size() - 1].addr, 26'h060000);
      dptr = dlog.size(); cptr = clog.size();
      mem[32'h60000] = 32'h00055550; mem[32'h60004] = 32'h0000DEAD;
      pulse_doorbell();
      expect_dma("t3_rd0", 1'b0, 26'h060000, 32'h0);
      expect_dma("t3_rd1", 1'b0, 26'h060004, 32'h0);
      expect_cmd("t3_cmd", 26'h055550, 1'b0, 32'hDEAD);
      expect_dma("t3_wb", 1'b1, 26'h060000, 32'h2);
      wait_index("t3_index1", 9'd1);
      expect_dma("t3_rd_next", 1'b0, 26'h060008, 32'h0);

      // 4: command timeout
      done_en = 1'b0;
      mem[32'h70000] = 32'h00000015; mem[32'h70004] = 32'h00000042;
      pulse_ring_load(14'h0070, 1'b1);
      abort0 = abort_cnt; irq0 = irq_cnt;
      pulse_doorbell();
      expect_dma("t4_rd0", 1'b0, 26'h070000, 32'h0);
      expect_dma("t4_rd1", 1'b0, 26'h070004, 32'h0);
      expect_cmd("t4_cmd", 26'h000010, 1'b0, 32'h42);
      expect_dma("t4_wb", 1'b1, 26'h070000, 32'h5);
      chk("t4_abort_cnt", abort_cnt - abort0, 1);
      chk("t4_abort_cycles", abort_cyc - hs_cyc, 15);
      chk("t4_timeout_err", timeout_err, 1);
      wait_index("t4_index", 9'd1);
      chk("t4_irq", irq_cnt - irq0, 1);
      expect_dma("t4_rd_next", 1'b0, 26'h070008, 32'h0);

      // 5: ring reload while a command is in WAIT
      done_en = 1'b1; done_delay = 6;
      mem[32'h70008] = 32'h00000021; mem[32'h7000C] = 32'h00000099;
      mem[32'h50000] = 32'h00000031; mem[32'h50004] = 32'h00000077;
      pulse_doorbell();
      expect_dma("t5_rd0", 1'b0, 26'h070008, 32'h0);
      expect_dma("t5_rd1", 1'b0, 26'h07000C, 32'h0);
      expect_cmd("t5_cmd", 26'h000020, 1'b0, 32'h99);
      @(negedge clk);
      pulse_ring_load(14'h0050, 1'b1);
      chk("t5_err_clr", timeout_err, 0);
      chk("t5_index_clr", ring_index, 0);
      expect_dma("t5_wb_old", 1'b1, 26'h070008, 32'h3);
      expect_dma("t5_rd_new", 1'b0, 26'h050000, 32'h0);
      chk("t5_index_hold", ring_index, 0);
      expect_dma("t5_rd_new1", 1'b0, 26'h050004, 32'h0);
      expect_cmd("t5_cmd_new", 26'h000030, 1'b0, 32'h77);
      expect_dma("t5_wb_new", 1'b1, 26'h050000, 32'h3);
      wait_index("t5_index", 9'd1);
      expect_dma("t5_rd_next", 1'b0, 26'h050008, 32'h0);

      // 6: slow DMA, then reset during WAIT
      ack_delay = 5; done_en = 1'b0;
      mem[32'h50008] = 32'h00000041; mem[32'h5000C] = 32'h00000005;
      pulse_doorbell();
      expect_dma("t6_rd0", 1'b0, 26'h050008, 32'h0);
      expect_dma("t6_rd1", 1'b0, 26'h05000C, 32'h0);
      expect_cmd("t6_cmd", 26'h000040, 1'b0, 32'h5);
      repeat (3) @(negedge clk);
      chk("t6_busy_wait", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_req", dma_req, 0);
      chk("t6_rst_addr", dma_addr, 0);
      chk("t6_rst_valid", cmd_valid, 0);
      chk("t6_rst_buf", cmd_buf_addr, 0);
      chk("t6_rst_lba", cmd_lba, 0);
      chk("t6_rst_index", ring_index, 0);
      chk("t6_rst_phase", consumer_phase, 0);
      chk("t6_rst_err", timeout_err, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_req", dma_req, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
